// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: framer state encoding, framing constants,
// default frame limits and the byte-wide reflected CRC-32 step.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          PREAMBLE_LEN  = 7;

   localparam int          MIN_LEN_DEF   = 60;
   localparam int          MAX_LEN_DEF   = 1514;
   localparam int          IFG_BYTES_DEF = 12;
   localparam int          CNT_W         = 11;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
   // Register value left after a frame plus its own FCS has been absorbed.
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/eth_tx_framer_crc.sv
// Ethernet CRC-32 engine: reflected register, seeded with all ones; crc_out is
// the complemented FCS ordered so byte [31:24] goes on the wire first.
module crc
   import eth_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        calc,
   input  logic [7:0]  data,
   output logic [31:0] crc_out,
   output logic        match
);

   logic [31:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear)
         crc_d = '1;
      else if (calc)
         crc_d = crc32_byte(crc_q, data);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         crc_q <= '1;
      else
         crc_q <= crc_d;
   end

   assign crc_out = ~{crc_q[7:0], crc_q[15:8], crc_q[23:16], crc_q[31:24]};
   assign match   = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet transmit framer: preamble, SFD, data, pad, FCS and IFG.
// Define ETH_TX_PAD_EN to pad short frames to MIN_LEN; without it frames go out unpadded.
module eth_tx_framer
   import eth_pkg::*;
#(
`ifdef ETH_TX_PAD_EN
   parameter int MIN_LEN   = MIN_LEN_DEF,
`endif
   parameter int MAX_LEN   = MAX_LEN_DEF,
   parameter int IFG_BYTES = IFG_BYTES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy,
   output logic       frame_done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_en_q, tx_en_d;
   logic             tx_er_q, tx_er_d;
   logic             done_q, done_d;
   logic             crc_clear, crc_calc;
   logic [31:0]      crc_out;
   logic             crc_match_unused;

   assign cnt_inc = cnt_q + 1'b1;

   // One counter serves preamble, data length, FCS byte index and gap timing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_data_d = 8'h00;
      tx_en_d   = 1'b0;
      tx_er_d   = 1'b0;
      done_d    = 1'b0;
      crc_calc  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (in_valid) state_d = ST_PRE;
         end
         ST_PRE: begin
            tx_data_d = PREAMBLE_BYTE;
            tx_en_d   = 1'b1;
            cnt_d     = cnt_inc;
            if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
               state_d = ST_SFD;
               cnt_d   = '0;
            end
         end
         ST_SFD: begin
            tx_data_d = SFD_BYTE;
            tx_en_d   = 1'b1;
            state_d   = ST_DATA;
         end
         ST_DATA: begin
            tx_en_d = 1'b1;
            // Underrun or oversize: the offending byte is replaced by the error cycle.
            if (!in_valid || (cnt_inc > CNT_W'(MAX_LEN))) begin
               tx_er_d = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IFG;
               cnt_d   = '0;
            end else begin
               tx_data_d = in_data;
               crc_calc  = 1'b1;
               cnt_d     = cnt_inc;
               if (in_last) begin
`ifdef ETH_TX_PAD_EN
                  if (cnt_inc < CNT_W'(MIN_LEN)) begin
                     state_d = ST_PAD;
                  end else begin
                     state_d = ST_FCS;
                     cnt_d   = '0;
                  end
`else
                  state_d = ST_FCS;
                  cnt_d   = '0;
`endif
               end
            end
         end
`ifdef ETH_TX_PAD_EN
         ST_PAD: begin
            tx_en_d  = 1'b1;
            crc_calc = 1'b1;
            cnt_d    = cnt_inc;
            if (cnt_inc == CNT_W'(MIN_LEN)) begin
               state_d = ST_FCS;
               cnt_d   = '0;
            end
         end
`endif
         ST_FCS: begin
            tx_en_d = 1'b1;
            cnt_d   = cnt_inc;
            case (cnt_q[1:0])
               2'd0:    tx_data_d = crc_out[31:24];
               2'd1:    tx_data_d = crc_out[23:16];
               2'd2:    tx_data_d = crc_out[15:8];
               default: tx_data_d = crc_out[7:0];
            endcase
            if (cnt_q[1:0] == 2'd3) begin
               done_d  = 1'b1;
               state_d = ST_IFG;
               cnt_d   = '0;
            end
         end
         ST_IFG: begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_W'(IFG_BYTES - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         tx_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
         tx_er_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         tx_er_q   <= tx_er_d;
         done_q    <= done_d;
      end
   end

   assign crc_clear = (state_q == ST_IDLE) || (state_q == ST_PRE) || (state_q == ST_IFG);

   crc u_crc (
      .clk     (clk),
      .reset   (reset),
      .clear   (crc_clear),
      .calc    (crc_calc),
      .data    (tx_data_d),
      .crc_out (crc_out),
      .match   (crc_match_unused)
   );

   assign in_ready   = (state_q == ST_DATA);
   assign busy       = (state_q != ST_IDLE);
   assign tx_data    = tx_data_q;
   assign tx_en      = tx_en_q;
   assign tx_er      = tx_er_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed/randomized bench for eth_tx_framer against a frame-level reference model.
module tb_eth_tx_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       tx_en, tx_er, busy, frame_done;

   logic        rc_clear = 1'b0, rc_calc = 1'b0;
   logic [7:0]  rc_data = 8'h00;
   logic [31:0] rc_out;
   logic        rc_match;

   int total = 0;
   int bad   = 0;

`ifdef ETH_TX_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   localparam int GAP = 13;   // IFG cycles plus the IDLE cycle

   eth_tx_framer dut (
      .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
      .busy(busy), .frame_done(frame_done)
   );

   crc u_ref (
      .clk(clk), .reset(rst), .clear(rc_clear), .calc(rc_calc), .data(rc_data),
      .crc_out(rc_out), .match(rc_match)
   );

   always #5 clk = ~clk;

   logic [10:0] lg[$];
   bit          logon = 1'b0;
   always @(negedge clk) if (logon) lg.push_back({tx_er, frame_done, tx_en, tx_data});

   logic [7:0] fd[$], dq[$], txq[$], expq[$];
   bit         lq[$], erq[$], dnq[$], experq[$], expdnq[$];
   int         gaps[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fcs_of(input logic [7:0] b[$]);
      logic [31:0] r;
      bit fb;
      r = 32'hFFFFFFFF;
      foreach (b[i]) for (int k = 0; k < 8; k++) begin
         fb = r[0] ^ b[i][k];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return ~r;
   endfunction

   task automatic pushx(input logic [7:0] b, input bit er, input bit dn);
      expq.push_back(b); experq.push_back(er); expdnq.push_back(dn);
   endtask

   // Expected wire bytes for frame fd with nsent bytes transmitted.
   task automatic add_frame(input int nsent, input bit aborted);
      logic [7:0]  body[$];
      logic [31:0] f;
      for (int i = 0; i < 7; i++) pushx(8'h55, 0, 0);
      pushx(8'hD5, 0, 0);
      for (int i = 0; i < nsent; i++) begin
         pushx(fd[i], 0, 0);
         body.push_back(fd[i]);
      end
      if (aborted) begin
         pushx(8'h00, 1, 1);
      end else begin
         while (PAD && body.size() < 60) begin
            body.push_back(8'h00);
            pushx(8'h00, 0, 0);
         end
         f = fcs_of(body);
         pushx(f[7:0], 0, 0); pushx(f[15:8], 0, 0); pushx(f[23:16], 0, 0); pushx(f[31:24], 0, 1);
      end
   endtask

   task automatic load(input bit with_last);
      foreach (fd[i]) begin
         dq.push_back(fd[i]);
         lq.push_back(with_last && (i == fd.size() - 1));
      end
   endtask

   task automatic new_test();
      lg.delete(); dq.delete(); lq.delete(); expq.delete(); experq.delete(); expdnq.delete();
      logon = 1'b1;
   endtask

   task automatic rand_fd(input int n);
      fd.delete();
      for (int i = 0; i < n; i++) fd.push_back(8'($urandom));
   endtask

   task automatic drive(input string tag, input int stop_after);
      int  idx, guard;
      bit  hs;
      idx = 0; guard = 0;
      in_valid = 1'b1; in_data = dq[0]; in_last = lq[0];
      while (idx < dq.size() && idx < stop_after && guard < 20000) begin
         @(negedge clk); hs = in_valid && in_ready;
         @(posedge clk); #1; guard++;
         if (hs) begin
            idx++;
            if (idx < dq.size() && idx < stop_after) begin
               in_data = dq[idx]; in_last = lq[idx];
            end
         end
      end
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      chk({tag, "_drive_timeout"}, 32'(guard >= 20000), 0);
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      @(negedge clk);
      while (busy && g < 4000) begin
         @(negedge clk); g++;
      end
      repeat (2) @(negedge clk);
      logon = 1'b0;
      chk({tag, "_idle"}, busy, 0);
   endtask

   task automatic extract();
      int run;
      bit seen;
      txq.delete(); erq.delete(); dnq.delete(); gaps.delete();
      run = 0; seen = 0;
      foreach (lg[i]) begin
         if (lg[i][8]) begin
            if (seen && run > 0) gaps.push_back(run);
            run = 0; seen = 1;
            txq.push_back(lg[i][7:0]); erq.push_back(lg[i][10]); dnq.push_back(lg[i][9]);
         end else run++;
      end
   endtask

   task automatic cmp_stream(input string tag);
      int mb, mf;
      mb = 0; mf = 0;
      extract();
      chk({tag, "_en_cycles"}, txq.size(), expq.size());
      foreach (expq[i]) if (i < txq.size()) begin
         if (txq[i] !== expq[i]) mb++;
         if ({erq[i], dnq[i]} !== {experq[i], expdnq[i]}) mf++;
      end
      chk({tag, "_bytes"}, mb, 0);
      chk({tag, "_flags"}, mf, 0);
   endtask

   // Replays captured wire bytes after the SFD into an independent CRC engine.
   task automatic ref_match(input string tag, input int start, input int len);
      rc_clear = 1'b1;
      @(posedge clk); #1;
      rc_clear = 1'b0; rc_calc = 1'b1;
      for (int i = 0; i < len; i++) begin
         rc_data = (start + i < txq.size()) ? txq[start + i] : 8'h00;
         @(posedge clk); #1;
      end
      rc_calc = 1'b0;
      chk({tag, "_match"}, rc_match, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, f1n;
      #12;
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_er", tx_er, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_ref_crc", rc_out, 0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // 64-byte frame 0x00..0x3F
      new_test();
      fd.delete();
      for (int i = 0; i < 64; i++) fd.push_back(8'(i));
      load(1); add_frame(64, 0);
      drive("f64", 1 << 30); wait_idle("f64");
      cmp_stream("f64");
      chk("f64_len76", txq.size(), 76);
      ref_match("f64", 8, txq.size() - 8);

      // single-byte frame
      new_test();
      fd.delete(); fd.push_back(8'hAB);
      load(1); add_frame(1, 0);
      drive("f1", 1 << 30); wait_idle("f1");
      cmp_stream("f1");
      chk("f1_len", txq.size(), PAD ? 72 : 13);
      ref_match("f1", 8, txq.size() - 8);

      // random lengths around the pad boundary
      for (int t = 0; t < 4; t++) begin
         n = (t == 0) ? 59 : (t == 1) ? 60 : int'($urandom_range(2, 120));
         new_test();
         rand_fd(n); load(1); add_frame(n, 0);
         drive("rnd", 1 << 30); wait_idle("rnd");
         cmp_stream($sformatf("rnd%0d_n%0d", t, n));
         ref_match($sformatf("rnd%0d", t), 8, txq.size() - 8);
      end

      // underrun after 20 bytes, then the next frame offered at once
      new_test();
      rand_fd(30); load(0); add_frame(20, 1);
      drive("urun", 20);
      @(posedge clk); #1;
      f1n = expq.size();
      rand_fd(10); dq.delete(); lq.delete(); load(1); add_frame(10, 0);
      drive("urun2", 1 << 30); wait_idle("urun");
      cmp_stream("urun");
      chk("urun_gap", (gaps.size() > 0) ? gaps[0] : -1, GAP);
      ref_match("urun2", f1n + 8, txq.size() - f1n - 8);

      // oversize: the 1515th byte triggers the abort
      new_test();
      rand_fd(1515); load(0); add_frame(1514, 1);
      drive("big", 1515); wait_idle("big");
      cmp_stream("big");

      // back-to-back frames with in_valid held high
      new_test();
      rand_fd(64); load(1); add_frame(64, 0);
      f1n = expq.size();
      rand_fd(5); load(1); add_frame(5, 0);
      drive("b2b", 1 << 30); wait_idle("b2b");
      cmp_stream("b2b");
      chk("b2b_gap", (gaps.size() > 0) ? gaps[0] : -1, GAP);
      ref_match("b2b_f1", 8, f1n - 8);
      ref_match("b2b_f2", f1n + 8, txq.size() - f1n - 8);

      // reset during FCS
      new_test();
      logon = 1'b0;
      rand_fd(64); load(1);
      drive("rstfcs", 1 << 30);
      @(posedge clk); @(posedge clk); #3;
      chk("rstfcs_in_fcs", tx_en, 1);
      rst = 1'b1; #1;
      chk("rstfcs_outs", {tx_en, tx_er, frame_done, in_ready, tx_data}, 0);
      chk("rstfcs_busy", busy, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      new_test();
      rand_fd(70); load(1); add_frame(70, 0);
      drive("after_rst", 1 << 30); wait_idle("after_rst");
      cmp_stream("after_rst");
      ref_match("after_rst", 8, txq.size() - 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
